// File: rtl/song_reader_if.sv
// Bundle of the MCU-facing, ROM-facing and note-player-facing signals of the
// song reader. The slave modport is the song reader's view. The master modport
// is the view of whoever plays the MCU, ROM and note player around it.
interface song_reader_if #(
    parameter int SONG_W = 4,
    parameter int IDX_W  = 5,
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6
);
    // MCU side
    logic                     play;
    logic                     reset_player;
    logic [SONG_W-1:0]        song;
    logic                     song_done;
    // note ROM side
    logic [SONG_W+IDX_W-1:0]  rom_addr;
    logic [NOTE_W+DUR_W-1:0]  rom_data;
    // note player side
    logic [NOTE_W-1:0]        note;
    logic [DUR_W-1:0]         duration;
    logic                     new_note;
    logic                     note_done;

    modport slave (
        input  play, reset_player, song, rom_data, note_done,
        output song_done, rom_addr, note, duration, new_note
    );

    modport master (
        output play, reset_player, song, rom_data, note_done,
        input  song_done, rom_addr, note, duration, new_note
    );
endinterface

// File: rtl/song_reader.sv
// Song reader: walks one song of a synchronous note ROM and hands each
// note/duration pair to the note player. It waits for note_done before moving
// to the next slot. A zero duration field marks the end of a song, and so does
// the last slot. Either one raises a one-cycle song_done pulse back to the MCU.
module song_reader #(
    parameter int SONG_W = 4,
    parameter int IDX_W  = 5,
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    song_reader_if.slave      sr
);
    localparam int ROM_W = NOTE_W + DUR_W;
    localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT_NOTE,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [SONG_W-1:0]   song_q, song_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic                new_note_q, new_note_d;

    logic [NOTE_W-1:0]   rom_note;
    logic [DUR_W-1:0]    rom_dur;

    assign rom_note = sr.rom_data[ROM_W-1:DUR_W];
    assign rom_dur  = sr.rom_data[DUR_W-1:0];

    // The ROM address comes only from registers, so it stays put while the FSM holds
    assign sr.rom_addr  = {song_q, idx_q};
    assign sr.note      = note_q;
    assign sr.duration  = dur_q;
    assign sr.new_note  = new_note_q;
    assign sr.song_done = (state_q == DONE);

    // State and datapath registers, cleared by the asynchronous reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            song_q     <= '0;
            note_q     <= '0;
            dur_q      <= '0;
            new_note_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            song_q     <= song_d;
            note_q     <= note_d;
            dur_q      <= dur_d;
            new_note_q <= new_note_d;
        end
    end

    // Next-state logic. reset_player overrides every state, and note/duration
    // keep their last values through it.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        song_d     = song_q;
        note_d     = note_q;
        dur_d      = dur_q;
        new_note_d = 1'b0;

        if (sr.reset_player) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // The song select is captured here only. A change mid-song waits for the next IDLE.
                    if (sr.play) begin
                        song_d  = sr.song;
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    // The ROM registers the stable address during this cycle
                    if (sr.play) begin
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    if (sr.play) begin
                        if (rom_dur == '0) begin
                            state_d = DONE;
                        end else begin
                            note_d     = rom_note;
                            dur_d      = rom_dur;
                            new_note_d = 1'b1;
                            state_d    = WAIT_NOTE;
                        end
                    end
                end
                WAIT_NOTE: begin
                    // The note player owns pausing, so play has no effect here. A note_done
                    // that lands on the strobe cycle refers to the previous note, so it is dropped.
                    if (sr.note_done && !new_note_q) begin
                        if (idx_q == IDX_LAST) begin
                            state_d = DONE;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = FETCH;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_song_reader.sv
// Directed bench for song_reader. It models the synchronous note ROM and acts as the MCU and the note player.
module tb_song_reader;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [11:0] rom [0:511];

    song_reader_if #(.SONG_W(4), .IDX_W(5), .NOTE_W(6), .DUR_W(6)) sr ();

    song_reader #(.SONG_W(4), .IDX_W(5), .NOTE_W(6), .DUR_W(6)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .sr    (sr)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data for an address appears one cycle later
    always @(posedge clk) sr.rom_data <= rom[sr.rom_addr];

    function automatic logic [5:0] note_fn(input int a);
        logic [5:0] t;
        t = 6'(a * 7 + 3);
        return t;
    endfunction

    function automatic logic [5:0] dur_fn(input int a);
        logic [5:0] t;
        t = 6'((a % 32) + 1);
        return t;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Plays song s to the end, answering each strobe with a one-cycle note_done.
    // lat is the number of cycles from the last note_done cycle to song_done.
    task automatic run_song(input int s, input int exp_n, input int lat);
        int n;
        int nd_cycle;
        bit pending;
        bit done;
        int a;
        n = 0; nd_cycle = 0; pending = 0; done = 0;
        sr.song = 4'(s);
        sr.play = 1'b1;
        for (int c = 0; c < 400 && !done; c++) begin
            tick();
            if (sr.note_done) sr.note_done = 1'b0;
            if (sr.new_note) begin
                a = s * 32 + n;
                check($sformatf("s%0d_note%0d", s, n), 32'(sr.note), 32'(rom[a][11:6]));
                check($sformatf("s%0d_dur%0d", s, n), 32'(sr.duration), 32'(rom[a][5:0]));
                n++;
                pending = 1;
            end else if (pending) begin
                sr.note_done = 1'b1;
                nd_cycle = c;
                pending = 0;
            end
            if (sr.song_done) begin
                done = 1;
                sr.play = 1'b0;
                check($sformatf("s%0d_done_lat", s), 32'(c - nd_cycle), 32'(lat));
            end
        end
        check($sformatf("s%0d_done_seen", s), 32'(done), 32'd1);
        check($sformatf("s%0d_strobes", s), 32'(n), 32'(exp_n));
        tick();
        check($sformatf("s%0d_done_pulse", s), 32'(sr.song_done), 32'd0);
        check($sformatf("s%0d_idle_addr", s), 32'(sr.rom_addr), 32'(s * 32));
        tick();
        check($sformatf("s%0d_idle_nostrobe", s), 32'(sr.new_note), 32'd0);
        check($sformatf("s%0d_idle_hold", s), 32'(sr.rom_addr), 32'(s * 32));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 512; a++) rom[a] = {note_fn(a), dur_fn(a)};
        rom[9'h040] = {6'd20, 6'd8};
        rom[9'h023] = {6'd9, 6'd0};

        sr.play = 1'b0;
        sr.reset_player = 1'b0;
        sr.song = 4'd0;
        sr.note_done = 1'b0;

        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst_addr", 32'(sr.rom_addr), 32'h0);
        check("rst_note", 32'(sr.note), 32'h0);
        check("rst_dur", 32'(sr.duration), 32'h0);
        check("rst_new_note", 32'(sr.new_note), 32'h0);
        check("rst_song_done", 32'(sr.song_done), 32'h0);
        tick();
        tick();
        rst = 1'b0;

        // Song 2, first note {20,8} with three-cycle latency
        sr.song = 4'd2;
        sr.play = 1'b1;
        tick();
        check("t2_fetch_addr", 32'(sr.rom_addr), 32'h040);
        check("t2_k1_strobe", 32'(sr.new_note), 32'h0);
        tick();
        check("t2_k2_strobe", 32'(sr.new_note), 32'h0);
        tick();
        check("t2_k3_strobe", 32'(sr.new_note), 32'h1);
        check("t2_note", 32'(sr.note), 32'd20);
        check("t2_dur", 32'(sr.duration), 32'd8);
        // note_done coincident with the strobe is dropped
        sr.note_done = 1'b1;
        tick();
        sr.note_done = 1'b0;
        check("t6_coincident_ignored", 32'(sr.rom_addr), 32'h040);
        check("t2_strobe_one_cycle", 32'(sr.new_note), 32'h0);
        tick();
        check("t6_still_waiting", 32'(sr.rom_addr), 32'h040);
        // Real note_done: next note three cycles later
        sr.note_done = 1'b1;
        tick();
        sr.note_done = 1'b0;
        check("t2_next_addr", 32'(sr.rom_addr), 32'h041);
        tick();
        check("t2_t2_strobe", 32'(sr.new_note), 32'h0);
        tick();
        check("t2_t3_strobe", 32'(sr.new_note), 32'h1);
        check("t2_note2", 32'(sr.note), 32'(note_fn(9'h041)));
        check("t2_dur2", 32'(sr.duration), 32'(dur_fn(9'h041)));

        // Asynchronous reset in the middle of a song
        #2 rst = 1'b1;
        #1;
        check("t1_addr", 32'(sr.rom_addr), 32'h0);
        check("t1_note", 32'(sr.note), 32'h0);
        check("t1_dur", 32'(sr.duration), 32'h0);
        check("t1_new_note", 32'(sr.new_note), 32'h0);
        check("t1_song_done", 32'(sr.song_done), 32'h0);
        sr.play = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Song 1 ends on the marker at slot 3
        run_song(1, 3, 3);

        // Song 15 runs through all 32 slots
        run_song(15, 32, 1);

        // Restart of song 15 from slot 0, with a pause in FETCH
        sr.play = 1'b1;
        tick();
        check("t4_restart_addr", 32'(sr.rom_addr), 32'h1E0);
        sr.play = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t5_pause%0d_strobe", i), 32'(sr.new_note), 32'h0);
            check($sformatf("t5_pause%0d_addr", i), 32'(sr.rom_addr), 32'h1E0);
        end
        sr.play = 1'b1;
        tick();
        check("t5_resume1_strobe", 32'(sr.new_note), 32'h0);
        tick();
        check("t5_resume2_strobe", 32'(sr.new_note), 32'h1);
        check("t5_note", 32'(sr.note), 32'(note_fn(9'h1E0)));
        check("t5_dur", 32'(sr.duration), 32'(dur_fn(9'h1E0)));

        // reset_player mid-note with a new song select
        tick();
        sr.reset_player = 1'b1;
        sr.song = 4'd5;
        tick();
        sr.reset_player = 1'b0;
        check("t6_rp_strobe", 32'(sr.new_note), 32'h0);
        check("t6_rp_addr", 32'(sr.rom_addr), 32'h1E0);
        check("t6_rp_note_hold", 32'(sr.note), 32'(note_fn(9'h1E0)));
        tick();
        check("t6_new_addr", 32'(sr.rom_addr), 32'h0A0);
        tick();
        tick();
        check("t6_strobe", 32'(sr.new_note), 32'h1);
        check("t6_note", 32'(sr.note), 32'(note_fn(9'h0A0)));
        check("t6_dur", 32'(sr.duration), 32'(dur_fn(9'h0A0)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
